// File: rtl/lock_arbiter_multi.sv
// Multi-slot lock manager: serves lock/unlock commands from accelerators over a command stream.
// Optional build macro LOCK_OWNER_CHECK_EN adds per-lock owner tracking (owner-only unlock, re-entrant lock).
module lock_arbiter_multi #(
  parameter int unsigned NUM_LOCKS    = 16,
  parameter int unsigned LOCK_ID_BITS = 8,
  parameter int unsigned ACC_ID_BITS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_in_tvalid,
  output logic                             cmd_in_tready,
  input  logic [63:0]                      cmd_in_tdata,
  input  logic [ACC_ID_BITS-1:0]           cmd_in_tid,
  output logic                             ack_out_tvalid,
  input  logic                             ack_out_tready,
  output logic [63:0]                      ack_out_tdata,
  output logic [ACC_ID_BITS-1:0]           ack_out_tdest,
  output logic [$clog2(NUM_LOCKS+1)-1:0]   locks_held,
  output logic                             err_pulse
);

  localparam int unsigned CNT_W = $clog2(NUM_LOCKS + 1);
  localparam int unsigned IDX_W = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  localparam logic [7:0] CMD_LOCK   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK = 8'h06;
  localparam logic [7:0] ACK_OK     = 8'h01;
  localparam logic [7:0] ACK_REJECT = 8'h00;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state, state_nxt;
  logic                     ready_q;
  logic [7:0]               cmd_code;
  logic [LOCK_ID_BITS-1:0]  lock_id;
  logic [ACC_ID_BITS-1:0]   acc_id;
  logic [NUM_LOCKS-1:0]     lock_bits;
  logic [63:0]              ack_tdata_q;
  logic [ACC_ID_BITS-1:0]   ack_tdest_q;
  logic [CNT_W-1:0]         locks_held_q;
  logic [CNT_W-1:0]         popcnt;

  logic [IDX_W-1:0]         idx;
  logic                     id_ok, held;
  logic                     set_bit, clr_bit, ack_ok, err;
  logic                     accept;

  // Header bits outside the opcode/ID fields carry no meaning here.
  logic unused_hdr;
  assign unused_hdr = ^cmd_in_tdata;

  assign accept = cmd_in_tvalid && ready_q;
  assign idx    = IDX_W'(lock_id);
  assign id_ok  = (32'(lock_id) < NUM_LOCKS);
  assign held   = id_ok && lock_bits[idx];

`ifdef LOCK_OWNER_CHECK_EN
  logic [ACC_ID_BITS-1:0] owner [NUM_LOCKS];
  logic                   owner_match;
  assign owner_match = (owner[idx] == acc_id);

  always_ff @(posedge clk) begin
    if (set_bit) owner[idx] <= acc_id;
  end
`endif

  always_comb begin
    state_nxt = state;
    set_bit   = 1'b0;
    clr_bit   = 1'b0;
    ack_ok    = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        state_nxt = IDLE;
        if (cmd_code == CMD_LOCK) begin
          state_nxt = RESP;
          if (!id_ok) err = 1'b1;
          else if (!held) begin
            set_bit = 1'b1;
            ack_ok  = 1'b1;
          end
`ifdef LOCK_OWNER_CHECK_EN
          else if (owner_match) ack_ok = 1'b1;
`endif
        end else if (cmd_code == CMD_UNLOCK) begin
          if (!id_ok) err = 1'b1;
`ifdef LOCK_OWNER_CHECK_EN
          else if (held && owner_match) clr_bit = 1'b1;
          else err = 1'b1;
`else
          else clr_bit = 1'b1;
`endif
        end else begin
          err = 1'b1;
        end
      end
      RESP: if (ack_out_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < NUM_LOCKS; i++) popcnt = popcnt + CNT_W'(lock_bits[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ready_q      <= 1'b0;
      cmd_code     <= '0;
      lock_id      <= '0;
      acc_id       <= '0;
      lock_bits    <= '0;
      ack_tdata_q  <= '0;
      ack_tdest_q  <= '0;
      locks_held_q <= '0;
    end else begin
      state        <= state_nxt;
      // Registered ready keeps tready low through reset and the cycle after.
      ready_q      <= (state_nxt == IDLE);
      locks_held_q <= popcnt;
      if (accept) begin
        cmd_code <= cmd_in_tdata[7:0];
        lock_id  <= cmd_in_tdata[8 +: LOCK_ID_BITS];
        acc_id   <= cmd_in_tid;
      end
      if (set_bit) lock_bits[idx] <= 1'b1;
      if (clr_bit) lock_bits[idx] <= 1'b0;
      if (state == EXEC) begin
        ack_tdata_q <= {48'h0, 8'(lock_id), (ack_ok ? ACK_OK : ACK_REJECT)};
        ack_tdest_q <= acc_id;
      end
    end
  end

  assign cmd_in_tready  = ready_q;
  assign ack_out_tvalid = (state == RESP);
  assign ack_out_tdata  = ack_tdata_q;
  assign ack_out_tdest  = ack_tdest_q;
  assign locks_held     = locks_held_q;
  assign err_pulse      = err;

endmodule

// File: tb/tb_lock_arbiter_multi.sv
// Directed self-checking bench for lock_arbiter_multi (NUM_LOCKS=16), covering both LOCK_OWNER_CHECK_EN builds.
module tb_lock_arbiter_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_in_tvalid;
  logic        cmd_in_tready;
  logic [63:0] cmd_in_tdata;
  logic [3:0]  cmd_in_tid;
  logic        ack_out_tvalid;
  logic        ack_out_tready;
  logic [63:0] ack_out_tdata;
  logic [3:0]  ack_out_tdest;
  logic [4:0]  locks_held;
  logic        err_pulse;

  int passed = 0;
  int total  = 0;

  logic        got;
  logic [63:0] ad;
  logic [3:0]  adest;

  lock_arbiter_multi #(.NUM_LOCKS(16), .LOCK_ID_BITS(8), .ACC_ID_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_in_tvalid(cmd_in_tvalid), .cmd_in_tready(cmd_in_tready),
    .cmd_in_tdata(cmd_in_tdata), .cmd_in_tid(cmd_in_tid),
    .ack_out_tvalid(ack_out_tvalid), .ack_out_tready(ack_out_tready),
    .ack_out_tdata(ack_out_tdata), .ack_out_tdest(ack_out_tdest),
    .locks_held(locks_held), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Drive one command; returns #1 after the accepting edge (the EXEC cycle).
  task automatic send_cmd(input logic [7:0] code, input logic [7:0] id, input logic [3:0] acc,
                          input logic [47:0] hi);
    @(negedge clk);
    cmd_in_tvalid = 1'b1;
    cmd_in_tdata  = {hi, id, code};
    cmd_in_tid    = acc;
    for (int i = 0; i < 30; i++) begin
      if (cmd_in_tready === 1'b1) begin
        @(posedge clk);
        #1 cmd_in_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_in_tvalid = 1'b0;
    total++;
    $display("FAIL send_timeout: tready=%b required 1", cmd_in_tready);
  endtask

  // Wait (bounded) for an ack and complete its handshake.
  task automatic get_ack(output logic g, output logic [63:0] d, output logic [3:0] dest);
    g = 1'b0; d = 'x; dest = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_out_tvalid === 1'b1) begin
        d = ack_out_tdata; dest = ack_out_tdest; g = 1'b1;
        ack_out_tready = 1'b1;
        @(posedge clk);
        #1 ack_out_tready = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_in_tready, ack_out_tvalid, ack_out_tdata, ack_out_tdest, locks_held, err_pulse} !== '0)
      $display("FAIL reset_outputs: tready=%b tvalid=%b tdata=%h tdest=%h held=%0d err=%b required all 0",
               cmd_in_tready, ack_out_tvalid, ack_out_tdata, ack_out_tdest, locks_held, err_pulse);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_lock;
    send_cmd(8'h04, 8'd3, 4'd2, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0301 || adest !== 4'd2) $display("FAIL lock_ok: tdata=%h tdest=%0d required 0301/2", ad, adest);
    else passed++;
    @(negedge clk);
    total++;
    if (locks_held !== 5'd1) $display("FAIL lock_held1: held=%0d required 1", locks_held); else passed++;
    send_cmd(8'h04, 8'd3, 4'd5, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0300 || adest !== 4'd5) $display("FAIL lock_reject: tdata=%h tdest=%0d required 0300/5", ad, adest);
    else passed++;
    @(negedge clk);
    total++;
    if (locks_held !== 5'd1) $display("FAIL lock_held2: held=%0d required 1", locks_held); else passed++;
  endtask

  task automatic test_unlock;
    send_cmd(8'h06, 8'd3, 4'd2, 48'h0);
    @(negedge clk);
    total++;
    if (ack_out_tvalid !== 1'b0 || err_pulse !== 1'b0 || cmd_in_tready !== 1'b0)
      $display("FAIL unlock_exec: tvalid=%b err=%b tready=%b required 0/0/0", ack_out_tvalid, err_pulse, cmd_in_tready);
    else passed++;
    @(negedge clk);
    total++;
    if (cmd_in_tready !== 1'b1 || ack_out_tvalid !== 1'b0)
      $display("FAIL unlock_gap: tready=%b tvalid=%b required 1/0", cmd_in_tready, ack_out_tvalid);
    else passed++;
    @(negedge clk);
    total++;
    if (locks_held !== 5'd0) $display("FAIL unlock_held: held=%0d required 0", locks_held); else passed++;
    send_cmd(8'h04, 8'd3, 4'd5, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0301 || adest !== 4'd5) $display("FAIL relock: tdata=%h tdest=%0d required 0301/5", ad, adest);
    else passed++;
  endtask

  task automatic test_errors;
    send_cmd(8'h04, 8'd16, 4'd1, 48'hDEAD_BEEF_CAFE);
    @(negedge clk);
    total++;
    if (err_pulse !== 1'b1) $display("FAIL range_err: err=%b required 1", err_pulse); else passed++;
    @(negedge clk);
    total++;
    if (err_pulse !== 1'b0 || ack_out_tvalid !== 1'b1 || ack_out_tdata !== 64'h1000 || ack_out_tdest !== 4'd1)
      $display("FAIL range_ack: err=%b tvalid=%b tdata=%h tdest=%0d required 0/1/1000/1",
               err_pulse, ack_out_tvalid, ack_out_tdata, ack_out_tdest);
    else passed++;
    get_ack(got, ad, adest);
    send_cmd(8'h09, 8'd2, 4'd1, 48'h0);
    @(negedge clk);
    total++;
    if (err_pulse !== 1'b1) $display("FAIL badcode_err: err=%b required 1", err_pulse); else passed++;
    @(negedge clk);
    total++;
    if (err_pulse !== 1'b0 || ack_out_tvalid !== 1'b0 || cmd_in_tready !== 1'b1)
      $display("FAIL badcode_drop: err=%b tvalid=%b tready=%b required 0/0/1", err_pulse, ack_out_tvalid, cmd_in_tready);
    else passed++;
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    send_cmd(8'h04, 8'd9, 4'd3, 48'h0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (ack_out_tvalid !== 1'b1 || ack_out_tdata !== 64'h0901 || ack_out_tdest !== 4'd3 || cmd_in_tready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    total++;
    if (bad != 0) $display("FAIL stall_hold: %0d bad cycles (last tvalid=%b tdata=%h tready=%b) required 0",
                           bad, ack_out_tvalid, ack_out_tdata, cmd_in_tready);
    else passed++;
    ack_out_tready = 1'b1;
    @(posedge clk);
    #1 ack_out_tready = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_in_tready !== 1'b1 || ack_out_tvalid !== 1'b0)
      $display("FAIL stall_release: tready=%b tvalid=%b required 1/0", cmd_in_tready, ack_out_tvalid);
    else passed++;
  endtask

  task automatic test_owner;
    send_cmd(8'h04, 8'd7, 4'd1, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0701 || adest !== 4'd1) $display("FAIL owner_lock: tdata=%h tdest=%0d required 0701/1", ad, adest);
    else passed++;
    send_cmd(8'h06, 8'd7, 4'd4, 48'h0);
    @(negedge clk);
`ifdef LOCK_OWNER_CHECK_EN
    total++;
    if (err_pulse !== 1'b1) $display("FAIL foreign_unlock_err: err=%b required 1", err_pulse); else passed++;
    send_cmd(8'h04, 8'd7, 4'd1, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0701 || adest !== 4'd1) $display("FAIL reentrant: tdata=%h tdest=%0d required 0701/1", ad, adest);
    else passed++;
`else
    total++;
    if (err_pulse !== 1'b0) $display("FAIL any_unlock_err: err=%b required 0", err_pulse); else passed++;
    send_cmd(8'h04, 8'd7, 4'd4, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0701 || adest !== 4'd4) $display("FAIL any_unlock_freed: tdata=%h tdest=%0d required 0701/4", ad, adest);
    else passed++;
    send_cmd(8'h04, 8'd7, 4'd4, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0700) $display("FAIL rerequest_reject: tdata=%h required 0700", ad); else passed++;
`endif
    @(negedge clk);
    total++;
    if (locks_held !== 5'd3) $display("FAIL owner_held: held=%0d required 3", locks_held); else passed++;
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    test_reset();
    for (int i = 0; i < 16; i++) begin
      send_cmd(8'h04, 8'(i), 4'd6, 48'h0);
      get_ack(got, ad, adest);
      if (ad[15:0] !== {8'(i), 8'h01}) bad++;
    end
    @(negedge clk);
    total++;
    if (bad != 0 || locks_held !== 5'd16) $display("FAIL fill_all: %0d bad acks held=%0d required 0/16", bad, locks_held);
    else passed++;
    send_cmd(8'h04, 8'd5, 4'd2, 48'h0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ack_out_tvalid !== 1'b1 || ack_out_tdata !== 64'h0500)
      $display("FAIL full_reject: tvalid=%b tdata=%h required 1/0500", ack_out_tvalid, ack_out_tdata);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({cmd_in_tready, ack_out_tvalid, ack_out_tdata, ack_out_tdest, locks_held, err_pulse} !== '0)
      $display("FAIL mid_reset: tready=%b tvalid=%b tdata=%h tdest=%h held=%0d err=%b required all 0",
               cmd_in_tready, ack_out_tvalid, ack_out_tdata, ack_out_tdest, locks_held, err_pulse);
    else passed++;
    rst = 1'b0;
    send_cmd(8'h04, 8'd0, 4'd2, 48'h0);
    get_ack(got, ad, adest);
    total++;
    if (ad !== 64'h0001 || adest !== 4'd2) $display("FAIL post_reset_lock: tdata=%h tdest=%0d required 0001/2", ad, adest);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    cmd_in_tvalid = 1'b0;
    cmd_in_tdata = '0;
    cmd_in_tid = '0;
    ack_out_tready = 1'b0;
    test_reset();
    test_lock();
    test_unlock();
    test_errors();
    test_backpressure();
    test_owner();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lock_arbiter_multi.md
Name: lock_arbiter_multi

Overview:
- Parametrised successor to the single-lock manager. Serves lock/unlock commands from hardware accelerators over a command stream and tracks up to NUM_LOCKS independent locks.
- Returns ACK_OK or ACK_REJECT to the requesting accelerator. A rejected accelerator retries.
- Sits in the OmpSs manager beside the scheduler and taskwait blocks, on hardware-runtime ID HWR_LOCK_ID (5'h15).

Parameters:
- NUM_LOCKS, 16, number of lock slots; 1..256.
- LOCK_ID_BITS, 8, width of the lock ID field in the command word.
- ACC_ID_BITS, 4, width of the accelerator ID (stream TID/TDEST).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_in_tvalid  in  1  command valid
- cmd_in_tready  out  1  command ready
- cmd_in_tdata  in  64  command word: [7:0] cmd code, [15:8] lock ID
- cmd_in_tid  in  ACC_ID_BITS  requesting accelerator
- ack_out_tvalid  out  1  ack valid
- ack_out_tready  in  1  ack ready
- ack_out_tdata  out  64  ack word: [7:0] ack code, [15:8] lock ID, rest 0
- ack_out_tdest  out  ACC_ID_BITS  destination accelerator
- locks_held  out  $clog2(NUM_LOCKS+1)  count of currently held locks
- err_pulse  out  1  one-cycle flag on a malformed or illegal command

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - cmd_in_tready=0, ack_out_tvalid=0, ack_out_tdata=0, ack_out_tdest=0.
  - locks_held=0, err_pulse=0.
  - All lock bits are cleared and FSM=IDLE.
- FSM states IDLE, EXEC, RESP.
  - IDLE: cmd_in_tready=1. A handshake (valid & ready) captures tdata and tid, then goes to EXEC.
  - EXEC (1 cycle): cmd_in_tready=0. Decodes the command and updates the table as below.
  - RESP: ack_out_tvalid=1 with tdata/tdest held stable until ack_out_tready. On handshake go to IDLE; cmd_in_tready rises the following cycle.
- Lock (code 8'h04):
  - If lock ID < NUM_LOCKS and the bit is clear: set the bit, ack ACK_OK (8'h01), go to RESP.
  - If the bit is set: no state change, ack ACK_REJECT (8'h00), go to RESP.
  - If lock ID >= NUM_LOCKS: ACK_REJECT plus err_pulse.
- Unlock (code 8'h06):
  - Clears the bit and sends no ack; EXEC returns to IDLE.
  - Unlock of a free lock has no effect.
  - Lock ID >= NUM_LOCKS: err_pulse, no effect.
- Any other code: dropped, err_pulse=1 for the EXEC cycle, return to IDLE.
- Latency: accept at cycle T, table update at the T+1 edge, ack_out_tvalid=1 from T+2. Minimum lock throughput is one command per 3 cycles, or 2 cycles for unlock.
- locks_held is registered and tracks the bit-vector popcount; it updates in the cycle after the table changes.
- Only the ID bits [LOCK_ID_BITS-1:0] of [15:8] are used. Upper header bits are ignored.
- Back-pressure: the FSM stalls in RESP indefinitely. No new command is accepted while an ack is pending.
- Reset mid-operation: a pending ack is discarded and all locks are released the next cycle. The requester must reissue.

Optional Feature:
LOCK_OWNER_CHECK_EN
- Defined:
  - A per-lock owner table (ACC_ID_BITS each) is written on a successful lock.
  - An unlock from a non-owner, or of a free lock, is ignored and raises err_pulse.
  - A lock request from the current owner on a held lock returns ACK_OK (re-entrant, no count change).
- Undefined:
  - No owner storage.
  - Any accelerator may unlock.
  - A re-request by the owner is rejected.

Test Plan:
1. Lock ID 3 from acc 2 -> ack tdata[7:0]=8'h01, [15:8]=3, tdest=2, locks_held=1. Repeat from acc 5 -> 8'h00, tdest=5, locks_held=1.
2. Unlock ID 3 from acc 2, then lock ID 3 from acc 5 -> no ack for the unlock, then 8'h01 to acc 5. Unlock-to-ready gap is 2 cycles.
3. Lock ID 16 with NUM_LOCKS=16 -> ACK_REJECT and err_pulse high for exactly 1 cycle. Command 8'h09 -> no ack and err_pulse.
4. Hold ack_out_tready=0 for 10 cycles after a lock -> tvalid stays 1, tdata stable, cmd_in_tready=0 throughout. Assert ready -> IDLE and tready=1 the next cycle.
5. Take locks 0..15 (locks_held=16), then assert rst mid-RESP -> next cycle all outputs reset, locks_held=0. Lock ID 0 then returns ACK_OK.
6. With LOCK_OWNER_CHECK_EN: acc 1 holds ID 7, acc 4 unlocks ID 7 -> err_pulse, lock still held. Acc 1 re-locks ID 7 -> ACK_OK.
